// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer controller: state codes, widths, LFSR constants.
// No latency or flow control of its own; pure declarations.
package reaction_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    STIM = 2'd2
  } state_e;

  localparam int          MS_W      = 14;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Restartable millisecond strobe: one-cycle tick when the cycle count hits TICK_DIV-1.
// First tick TICK_DIV cycles after restart; restart has no backpressure, it simply wins.
module ms_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || (cnt_q == TERM)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == TERM);

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer sequencer: random fore-period, stimulus LED, response timing in ms.
// All outputs registered; start ignored while busy, react ignored in IDLE.
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int TICK_DIV    = 100000,
  parameter int WAIT_MIN_MS = 1000,
  parameter int RANGE_BITS  = 11,
  parameter int MAX_MS      = 9999
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_btn,
  input  logic            react_btn,
  output logic            led,
  output logic            busy,
  output logic [MS_W-1:0] reaction_ms,
  output logic            result_valid,
  output logic            too_early,
  output logic            timeout
);

  localparam logic [1:0]      ST_IDLE    = IDLE;
  localparam logic [1:0]      ST_WAIT    = WAIT;
  localparam logic [1:0]      ST_STIM    = STIM;
  localparam logic [MS_W-1:0] WAIT_MIN_L = MS_W'(WAIT_MIN_MS);
  localparam logic [MS_W-1:0] MAX_L      = MS_W'(MAX_MS);

  logic [1:0]      state_q, state_d;
  logic [15:0]     lfsr_q;
  logic [MS_W-1:0] ms_q, ms_d;
  logic [MS_W-1:0] target_q, target_d;
  logic [MS_W-1:0] rms_q, rms_d;
  logic            rv_q, rv_d;
  logic            early_q, early_d;
  logic            tmo_q, tmo_d;
  logic            led_q, busy_q;
  logic            restart;
  logic            tick;

  ms_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart),
    .tick    (tick)
  );

  // Terminal-count checks use the registered counter, so a press in the
  // same cycle always takes priority over the phase change.
  always_comb begin
    state_d  = state_q;
    ms_d     = ms_q;
    target_d = target_q;
    rms_d    = rms_q;
    rv_d     = rv_q;
    early_d  = early_q;
    tmo_d    = tmo_q;
    restart  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        restart = 1'b1;
        if (start_btn) begin
          target_d = WAIT_MIN_L + MS_W'(lfsr_q[RANGE_BITS-1:0]);
          rv_d     = 1'b0;
          early_d  = 1'b0;
          tmo_d    = 1'b0;
          ms_d     = '0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (react_btn) begin
          state_d = ST_IDLE;
          early_d = 1'b1;
          rv_d    = 1'b1;
          rms_d   = '0;
        end else if (ms_q == target_q) begin
          state_d = ST_STIM;
          ms_d    = '0;
          restart = 1'b1;
        end else if (tick) begin
          ms_d = ms_q + MS_W'(1);
        end
      end
      ST_STIM: begin
        if (react_btn) begin
          state_d = ST_IDLE;
          rms_d   = ms_q;
          rv_d    = 1'b1;
        end else if (ms_q == MAX_L) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
          rv_d    = 1'b1;
          rms_d   = MAX_L;
        end else if (tick) begin
          ms_d = ms_q + MS_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= LFSR_SEED;
      ms_q     <= '0;
      target_q <= '0;
      rms_q    <= '0;
      rv_q     <= 1'b0;
      early_q  <= 1'b0;
      tmo_q    <= 1'b0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_next(lfsr_q);
      ms_q     <= ms_d;
      target_q <= target_d;
      rms_q    <= rms_d;
      rv_q     <= rv_d;
      early_q  <= early_d;
      tmo_q    <= tmo_d;
      led_q    <= (state_d == ST_STIM);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign led          = led_q;
  assign busy         = busy_q;
  assign reaction_ms  = rms_q;
  assign result_valid = rv_q;
  assign too_early    = early_q;
  assign timeout      = tmo_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Randomised rounds against a cycle-arithmetic model; a monitor scores each finished round.
module tb_reaction_timer_ctrl;

  localparam int TB_TICK     = 4;
  localparam int TB_WAIT_MIN = 3;
  localparam int TB_RANGE    = 2;
  localparam int TB_MAX      = 20;
  localparam int M_STIM      = 0;
  localparam int M_EARLY     = 1;
  localparam int M_TMO       = 2;

  initial assert (TB_WAIT_MIN + (1 << TB_RANGE) - 1 <= 16383)
    else $fatal(1, "fore-period does not fit the 14-bit counter");

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_btn = 1'b0;
  logic        react_btn = 1'b0;
  logic        led, busy, result_valid, too_early, timeout;
  logic [13:0] reaction_ms;

  reaction_timer_ctrl #(
    .TICK_DIV    (TB_TICK),
    .WAIT_MIN_MS (TB_WAIT_MIN),
    .RANGE_BITS  (TB_RANGE),
    .MAX_MS      (TB_MAX)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_btn    (start_btn),
    .react_btn    (react_btn),
    .led          (led),
    .busy         (busy),
    .reaction_ms  (reaction_ms),
    .result_valid (result_valid),
    .too_early    (too_early),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ms;
    int early;
    int tmo;
    int end_off;
    int led_off;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          last_exp_ms = 0;
  logic [15:0] lfsr_m;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference pseudo-random source: taps 16,14,13,11, reloaded only by reset
  always @(posedge clk) begin
    cyc++;
    if (!reset_n) lfsr_m = 16'hACE1;
    else lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  // Monitor: scores each round when result_valid rises
  logic p_busy = 1'b0, p_led = 1'b0, p_rv = 1'b0;
  int   accept_cyc = 0, led_cyc = 0;
  bit   led_seen = 1'b0;
  always @(negedge clk) begin
    exp_t x;
    if (busy && !p_busy) begin
      accept_cyc = cyc;
      led_seen   = 1'b0;
      chk("flags_clear_on_start", int'({result_valid, too_early, timeout}), 0);
      chk("ms_held_on_start", int'(reaction_ms), last_exp_ms);
    end
    if (led && !p_led) begin
      led_seen = 1'b1;
      led_cyc  = cyc;
    end
    if (result_valid && !p_rv) begin
      chk("result_queued", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("reaction_ms", int'(reaction_ms), x.ms);
        chk("too_early", int'(too_early), x.early);
        chk("timeout", int'(timeout), x.tmo);
        chk("round_length", cyc - accept_cyc, x.end_off);
        if (x.led_off > 0) chk("led_delay", led_seen ? led_cyc - accept_cyc : -1, x.led_off);
        else chk("led_never_lit", int'(led_seen), 0);
        chk("led_off_at_end", int'(led), 0);
        chk("busy_off_at_end", int'(busy), 0);
        last_exp_ms = x.ms;
      end
    end
    p_busy = busy;
    p_led  = led;
    p_rv   = result_valid;
  end

  // One round: model the expected outcome from cycle arithmetic, queue it, then drive pins
  task automatic run_round(input int mode, input int p, input bit spur_en, input bit rb_start,
                           input int wt_force, output int wt_o);
    int   wt, ledoff, e, end_off, spur;
    exp_t x;
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    chk("idle_before_start", int'(busy), 0);
    @(negedge clk);
    wt     = (wt_force > 0) ? wt_force : TB_WAIT_MIN + int'(lfsr_m[1:0]);
    wt_o   = wt;
    ledoff = wt * TB_TICK + 1;
    x.early = 0; x.tmo = 0; x.led_off = ledoff;
    if (mode == M_EARLY) begin
      e = (p <= 0 || p > ledoff) ? ledoff : p;
      end_off = e; x.ms = 0; x.early = 1; x.led_off = 0;
    end else if (mode == M_STIM && p >= 1 && p <= TB_MAX * TB_TICK + 1) begin
      e = ledoff + p;
      end_off = e;
      x.ms = ((p - 1) / TB_TICK > TB_MAX) ? TB_MAX : (p - 1) / TB_TICK;
    end else begin
      e = 0;
      end_off = ledoff + TB_MAX * TB_TICK + 1;
      x.ms = TB_MAX; x.tmo = 1;
    end
    x.end_off = end_off;
    exp_q.push_back(x);
    start_btn = 1'b1;
    react_btn = rb_start;
    spur = (spur_en && end_off > 1) ? $urandom_range(1, end_off - 1) : 0;
    for (int c = 1; c <= end_off; c++) begin
      @(negedge clk);
      start_btn = (c == spur);
      react_btn = (c == e);
    end
    @(negedge clk);
    start_btn = 1'b0;
    react_btn = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_led"}, int'(led), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_reaction_ms"}, int'(reaction_ms), 0);
    chk({tag, "_result_valid"}, int'(result_valid), 0);
    chk({tag, "_too_early"}, int'(too_early), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
  endtask

  initial begin
    int wt_first, wt, m;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    reset_n = 1'b1;
    run_round(M_STIM, 21, 1'b0, 1'b0, 0, wt_first);   // 5 ticks into STIM
    run_round(M_EARLY, 2, 1'b0, 1'b0, 0, wt);
    run_round(M_TMO, 0, 1'b0, 1'b0, 0, wt);
    run_round(M_STIM, 28, 1'b0, 1'b0, 0, wt);         // coincident with 7th tick
    run_round(M_STIM, 81, 1'b0, 1'b0, 0, wt);         // coincident with reaching MAX
    run_round(M_EARLY, 0, 1'b0, 1'b0, 0, wt);         // coincident with wait_target
    run_round(M_STIM, 1, 1'b1, 1'b1, 0, wt);
    run_round(M_TMO, 0, 1'b1, 1'b0, 0, wt);
    for (int r = 0; r < 30; r++) begin
      m = $urandom_range(0, 3);
      case (m)
        0: run_round(M_STIM, $urandom_range(1, 81), $urandom_range(0, 1) == 1,
                     $urandom_range(0, 1) == 1, 0, wt);
        1: run_round(M_EARLY, $urandom_range(1, 30), $urandom_range(0, 1) == 1,
                     $urandom_range(0, 1) == 1, 0, wt);
        2: run_round(M_TMO, 0, $urandom_range(0, 1) == 1, 1'b0, 0, wt);
        default: run_round(M_STIM, TB_TICK * $urandom_range(1, TB_MAX), 1'b1, 1'b0, 0, wt);
      endcase
    end
    // Abort a round in STIM with a one-cycle reset
    @(negedge clk);
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    for (int i = 0; i < 100 && !led; i++) @(negedge clk);
    chk("led_before_reset", int'(led), 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("mid_reset");
    last_exp_ms = 0;
    reset_n = 1'b1;
    run_round(M_STIM, 9, 1'b0, 1'b0, wt_first, wt);  // same fore-period as after power-up
    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
